// File: rtl/axi_dw_ar_scheduler_pkg.sv
// Shared types and helpers for the AXI downsizer read-address scheduler.
// Holds the packer command format and the narrow-beat arithmetic.
package axi_dw_ar_scheduler_pkg;

    localparam int unsigned DwAddrWidth   = 32;
    localparam int unsigned DwIdWidth     = 4;
    localparam int unsigned DwSiBytesLog2 = 5;
    localparam int unsigned DwMiBytesLog2 = 2;
    localparam int unsigned DwOffsetWidth = DwSiBytesLog2 - DwMiBytesLog2;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    typedef struct packed {
        logic [DwIdWidth-1:0]     id;
        logic [2:0]               ratio_log2;
        logic [DwOffsetWidth-1:0] offset;
        logic                     last;
        logic                     err;
    } ar_cmd_t;

    typedef struct packed {
        logic [11:0]              n;
        logic [DwOffsetWidth-1:0] s;
    } beats_t;

    typedef enum logic [1:0] {StIdle, StIssue, StErrCmd} state_e;

    // s: narrow lane of the first beat; n: narrow beats needed to cover the wide burst.
    function automatic beats_t dw_narrow_beats(input logic [DwAddrWidth-1:0] addr,
                                               input logic [7:0] len,
                                               input logic [2:0] size,
                                               input logic [2:0] mi_log2);
        beats_t                 res;
        logic [DwAddrWidth-1:0] lane;
        logic [2:0]             ratio;
        lane  = (addr & ((DwAddrWidth'(1) << size) - DwAddrWidth'(1))) >> mi_log2;
        ratio = size - mi_log2;
        res.s = DwOffsetWidth'(lane);
        res.n = ((12'(len) + 12'd1) << ratio) - 12'(res.s);
        return res;
    endfunction

endpackage

// File: rtl/axi_dw_ar_scheduler.sv
// Read-address scheduler of the AXI downsizer: one wide AR becomes one or more narrow ARs
// (split at 256 beats) plus one packer command per issued burst.
module axi_dw_ar_scheduler
    import axi_dw_ar_scheduler_pkg::*;
#(
    parameter int unsigned AddrWidth   = DwAddrWidth,
    parameter int unsigned IdWidth     = DwIdWidth,
    parameter int unsigned SiBytesLog2 = DwSiBytesLog2,
    parameter int unsigned MiBytesLog2 = DwMiBytesLog2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 slv_ar_valid_i,
    output logic                 slv_ar_ready_o,
    input  logic [IdWidth-1:0]   slv_ar_id_i,
    input  logic [AddrWidth-1:0] slv_ar_addr_i,
    input  logic [7:0]           slv_ar_len_i,
    input  logic [2:0]           slv_ar_size_i,
    input  logic [1:0]           slv_ar_burst_i,
    output logic                 mst_ar_valid_o,
    input  logic                 mst_ar_ready_i,
    output logic [IdWidth-1:0]   mst_ar_id_o,
    output logic [AddrWidth-1:0] mst_ar_addr_o,
    output logic [7:0]           mst_ar_len_o,
    output logic [2:0]           mst_ar_size_o,
    output logic [1:0]           mst_ar_burst_o,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output ar_cmd_t              cmd_o
);

    localparam int unsigned OffsetWidth = SiBytesLog2 - MiBytesLog2;
    localparam logic [11:0] SegBeats    = 12'd256;
    localparam logic [2:0]  MiSize      = 3'(MiBytesLog2);
    localparam logic [AddrWidth-1:0] MiMask   = AddrWidth'(2 ** MiBytesLog2 - 1);
    localparam logic [AddrWidth-1:0] SegBytes = AddrWidth'(256 * 2 ** MiBytesLog2);

    state_e               state_q;
    logic                 slv_ready_q, mst_valid_q, cmd_valid_q, mst_sent_q, cmd_sent_q;
    logic [AddrWidth-1:0] addr_q, next_addr_q;
    logic [7:0]           len_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic [11:0]          rem_q;
    ar_cmd_t              cmd_q;

    beats_t                 beats;
    logic [OffsetWidth-1:0] first_offset;
    logic [11:0]            first_seg, next_seg;
    logic                   mst_done, cmd_done;

    assign beats        = dw_narrow_beats(slv_ar_addr_i, slv_ar_len_i, slv_ar_size_i, MiSize);
    assign first_offset = beats.s;
    assign first_seg    = (beats.n > SegBeats) ? SegBeats : beats.n;
    assign next_seg     = (rem_q > SegBeats) ? SegBeats : rem_q;
    assign mst_done     = mst_sent_q | (mst_valid_q & mst_ar_ready_i);
    assign cmd_done     = cmd_sent_q | (cmd_valid_q & cmd_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            slv_ready_q <= 1'b0;
            mst_valid_q <= 1'b0;
            cmd_valid_q <= 1'b0;
            mst_sent_q  <= 1'b0;
            cmd_sent_q  <= 1'b0;
            addr_q      <= '0;
            next_addr_q <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            rem_q       <= '0;
            cmd_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    slv_ready_q <= 1'b1;
                    if (slv_ar_valid_i && slv_ready_q) begin
                        slv_ready_q <= 1'b0;
                        mst_sent_q  <= 1'b0;
                        cmd_sent_q  <= 1'b0;
                        cmd_q.id    <= slv_ar_id_i;
                        cmd_q.err   <= 1'b0;
                        if (slv_ar_size_i <= MiSize) begin
                            addr_q           <= slv_ar_addr_i;
                            len_q            <= slv_ar_len_i;
                            size_q           <= slv_ar_size_i;
                            burst_q          <= slv_ar_burst_i;
                            rem_q            <= '0;
                            cmd_q.ratio_log2 <= '0;
                            cmd_q.offset     <= '0;
                            cmd_q.last       <= 1'b1;
                            mst_valid_q      <= 1'b1;
                            cmd_valid_q      <= 1'b1;
                            state_q          <= StIssue;
                        end else if (slv_ar_burst_i == BurstIncr) begin
                            addr_q           <= slv_ar_addr_i;
                            next_addr_q      <= (slv_ar_addr_i & ~MiMask) + SegBytes;
                            len_q            <= 8'(first_seg - 12'd1);
                            size_q           <= MiSize;
                            burst_q          <= BurstIncr;
                            rem_q            <= beats.n - first_seg;
                            cmd_q.ratio_log2 <= slv_ar_size_i - MiSize;
                            cmd_q.offset     <= first_offset;
                            cmd_q.last       <= (beats.n <= SegBeats);
                            mst_valid_q      <= 1'b1;
                            cmd_valid_q      <= 1'b1;
                            state_q          <= StIssue;
                        end else begin
                            // Narrowing a FIXED/WRAP burst is unsupported: the packer answers SLVERR.
                            cmd_q.ratio_log2 <= '0;
                            cmd_q.offset     <= '0;
                            cmd_q.last       <= 1'b1;
                            cmd_q.err        <= 1'b1;
                            cmd_valid_q      <= 1'b1;
                            state_q          <= StErrCmd;
                        end
                    end
                end
                StIssue: begin
                    if (mst_done && cmd_done) begin
                        mst_sent_q <= 1'b0;
                        cmd_sent_q <= 1'b0;
                        if (rem_q == 12'd0) begin
                            mst_valid_q <= 1'b0;
                            cmd_valid_q <= 1'b0;
                            slv_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            addr_q       <= next_addr_q;
                            next_addr_q  <= next_addr_q + SegBytes;
                            len_q        <= 8'(next_seg - 12'd1);
                            rem_q        <= rem_q - next_seg;
                            cmd_q.offset <= '0;
                            cmd_q.last   <= (rem_q <= SegBeats);
                            mst_valid_q  <= 1'b1;
                            cmd_valid_q  <= 1'b1;
                        end
                    end else begin
                        if (mst_valid_q && mst_ar_ready_i) begin
                            mst_valid_q <= 1'b0;
                            mst_sent_q  <= 1'b1;
                        end
                        if (cmd_valid_q && cmd_ready_i) begin
                            cmd_valid_q <= 1'b0;
                            cmd_sent_q  <= 1'b1;
                        end
                    end
                end
                StErrCmd: begin
                    if (cmd_valid_q && cmd_ready_i) begin
                        cmd_valid_q <= 1'b0;
                        slv_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign slv_ar_ready_o = slv_ready_q;
    assign mst_ar_valid_o = mst_valid_q;
    assign mst_ar_id_o    = cmd_q.id;
    assign mst_ar_addr_o  = addr_q;
    assign mst_ar_len_o   = len_q;
    assign mst_ar_size_o  = size_q;
    assign mst_ar_burst_o = burst_q;
    assign cmd_valid_o    = cmd_valid_q;
    assign cmd_o          = cmd_q;

endmodule
